uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Byte queue and start-handshake sequencer sitting directly upstream of the `Uart8` transmit interface. Host logic pushes bytes at clock rate. The feeder buffers them in a FIFO and presents them one at a time to `Uart8`, using `txStart`/`in` and observing `txBusy`. This decouples bursty producers from the 9600-baud serial line.

## Interface
**Parameters**
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `AW`, `$clog2(DEPTH)`: pointer width (derived; not overridden).

**Ports**
- `clk` in 1: system clock (12 MHz on target).
- `rstN` in 1: reset; asynchronous, active-low.
- `en` in 1: transmit enable; also drives `txEn` on `Uart8`.
- `flush` in 1: synchronous FIFO clear.
- `wrEn` in 1: push strobe.
- `wrData` in 8: byte to push.
- `full` out 1: FIFO holds `DEPTH` bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `count` out AW+1: current occupancy, 0..DEPTH.
- `overflow` out 1: one-cycle pulse when a push is dropped.
- `txEn` out 1: equals `en`, combinational.
- `txStart` out 1: start request to `Uart8`; registered.
- `txByte` out 8: byte to `Uart8` `in`; registered, stable while `txStart`=1.
- `txBusy` in 1: from `Uart8`.
- `txDone` in 1: from `Uart8`; monitored only; it does not gate the FSM.

## Operation
- The FIFO uses circular read/write pointers of width AW, which wrap at DEPTH. `count` is a separate up/down counter.
- Push is accepted when `wrEn` && !`full` && !`flush`.
  - Push while `full` drops the byte, pulses `overflow`, and leaves contents unchanged.
  - `full` is evaluated on the pre-edge count, so a same-cycle pop does not rescue the push.
- Pop occurs only on the START→WAIT transition. A simultaneous accepted push and pop leaves `count` unchanged.
- FSM states:
  - **IDLE**: `txStart`=0. If `en` && !`empty` && !`flush`, load `txByte` ← head and go to START.
  - **START**: `txStart`=1.
    - If `txBusy`=1: pop, `txStart`←0, go to WAIT.
    - Else if !`en` or `flush`: `txStart`←0, go to IDLE with no pop.
  - **WAIT**: `txStart`=0. When `txBusy`=0, go to IDLE. Neither `en` nor `flush` aborts WAIT; the in-flight byte always completes.
- `flush`: read pointer ← write pointer, `count`←0, same edge. It takes priority over a push in the same cycle.
- Reset: pointers 0, `count` 0, state IDLE, `txStart` 0, `txByte` 8'h00, `overflow` 0.
  - Reset values after reset: `empty`=1, `full`=0.
  - Reset mid-transfer drops `txStart` immediately. `Uart8` is not reset by this block.

## Timing
- First-byte latency:
  - Push at edge k makes `empty`=0 after edge k.
  - START is entered and `txStart`=1 after edge k+1.
- `txStart` stays high until the edge after `txBusy` is sampled high. There is no upper bound: the feeder holds the request as long as `Uart8` takes.
- Back-to-back bytes:
  - `txBusy` falls and is sampled at edge j, giving IDLE after j.
  - START and next `txStart`=1 follow after edge j+1.
  - Minimum gap between `txBusy` falling and the next `txStart` is 2 cycles.
- `overflow` is high for exactly the cycle after the dropped push edge.
- `full`, `empty` and `count` are registered and consistent on every cycle.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding constants `ST_IDLE`, `ST_START`, `ST_WAIT` (2-bit).
  - Byte width constant `UART_DATA_W`=8.
- One sub-module, `uart_byte_fifo`, contains the storage, pointers, `count`, `full`/`empty`/`overflow` and flush. The pop strobe comes from the FSM.
- The top level contains the FSM and the `txByte`/`txStart` registers only.

## Test plan
- **Single byte:** reset; `en`=1; push 8'b10001010.
  - `txStart` rises 2 cycles after the push.
  - `count` reaches 0 on the cycle after `txBusy` is sampled high.
  - `Uart8` receiver outputs 10001010.
- **Burst of 3:** push 8'h55, 8'hA3, 8'h0F on consecutive cycles.
  - `count`=3, then decrements once per start.
  - Bytes appear in order.
  - Each `txStart` is exactly 2 cycles after the prior `txBusy` fall.
- **Overflow:** `en`=0; push 17 bytes 8'h00..8'h10.
  - `full`=1 after 16 pushes.
  - The 17th push pulses `overflow` for 1 cycle.
  - Set `en`=1: 8'h00..8'h0F are sent, and 8'h10 is never sent.
- **Wrap-around:** DEPTH=4.
  - Push 3, drain, then push 4.
  - Read order stays correct across the pointer wrap, and `full`=1 at `count`=4.
- **Flush and disable mid-operation:**
  - `flush` in START: `txStart` drops the next cycle, `count`=0, no byte is sent.
  - `en`←0 in WAIT: the current byte completes and the next byte is held.
- **Async reset in WAIT:** assert `rstN`=0 between edges.
  - `txStart`=0, `count`=0 and `empty`=1 without a clock edge.
  - After release, the FSM is IDLE and no spurious `txStart` occurs.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the Uart8 transmit feeder: byte width and the
// feeder FSM state encoding.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } txState_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// Circular byte FIFO in front of the Uart8 transmitter.
//
// Ports:
//   clk, rstN        system clock, async active-low reset
//   flush            synchronous clear (wins over a same-cycle push)
//   wrEn, wrData     push strobe and byte
//   rdEn             pop strobe from the feeder FSM
//   rdData           head byte (combinational read of the read pointer)
//   full, empty      registered occupancy flags
//   count            registered occupancy, 0..DEPTH
//   overflow         one-cycle pulse after a push that hit a full FIFO
// ---------------------------------------------------------------------------
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   flush,
    input  logic                   wrEn,
    input  logic [UART_DATA_W-1:0] wrData,
    input  logic                   rdEn,
    output logic [UART_DATA_W-1:0] rdData,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count,
    output logic                   overflow
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wrPtr;
    logic [AW-1:0]          rdPtr;
    logic [AW:0]            countNext;
    logic                   push;
    logic                   pop;

    // full is the pre-edge flag, so a pop in the same cycle cannot make room
    assign push   = wrEn && !full && !flush;
    assign pop    = rdEn && !empty && !flush;
    assign rdData = mem[rdPtr];

    always_comb begin
        countNext = count;
        if (flush) begin
            countNext = '0;
        end else if (push && !pop) begin
            countNext = count + 1'b1;
        end else if (!push && pop) begin
            countNext = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            // no push can coincide with flush, so wrPtr is the post-edge value
            if (flush) begin
                rdPtr <= wrPtr;
            end else if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count    <= countNext;
            full     <= (countNext == FULL_CNT);
            empty    <= (countNext == '0);
            overflow <= wrEn && full && !flush;
        end
    end

    // storage is not reset; occupancy alone defines valid contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= wrData;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Buffers host bytes and hands them one at a time to Uart8 using a
// txStart / txBusy handshake.
//
// Ports:
//   clk, rstN        system clock, async active-low reset
//   en               transmit enable, forwarded to Uart8 as txEn
//   flush            synchronous FIFO clear
//   wrEn, wrData     host push strobe and byte
//   full, empty      FIFO occupancy flags
//   count            FIFO occupancy, 0..DEPTH
//   overflow         pulse after a dropped push
//   txEn             equals en
//   txStart          registered start request to Uart8
//   txByte           registered byte to Uart8, stable while txStart is high
//   txBusy           Uart8 busy
//   txDone           Uart8 done (observed only)
//
// State     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no request; waits for en, a byte in the FIFO and no flush
// ST_START  | txStart high, txByte holds the head byte until Uart8 is busy
// ST_WAIT   | byte accepted and popped; waits for Uart8 to go idle
// ---------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   wrEn,
    input  logic [UART_DATA_W-1:0] wrData,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count,
    output logic                   overflow,
    output logic                   txEn,
    output logic                   txStart,
    output logic [UART_DATA_W-1:0] txByte,
    input  logic                   txBusy,
    input  logic                   txDone
);

    txState_t               state;
    txState_t               stateNext;
    logic                   txStartNext;
    logic [UART_DATA_W-1:0] txByteNext;
    logic [UART_DATA_W-1:0] headByte;
    logic                   pop;
    logic                   unusedTxDone;

    assign txEn         = en;
    assign unusedTxDone = txDone;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .clk      (clk),
        .rstN     (rstN),
        .flush    (flush),
        .wrEn     (wrEn),
        .wrData   (wrData),
        .rdEn     (pop),
        .rdData   (headByte),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= ST_IDLE;
            txStart <= 1'b0;
            txByte  <= '0;
        end else begin
            state   <= stateNext;
            txStart <= txStartNext;
            txByte  <= txByteNext;
        end
    end

    always_comb begin
        stateNext   = state;
        txStartNext = txStart;
        txByteNext  = txByte;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                txStartNext = 1'b0;
                if (en && !empty && !flush) begin
                    txByteNext  = headByte;
                    txStartNext = 1'b1;
                    stateNext   = ST_START;
                end
            end
            ST_START: begin
                // acceptance by Uart8 wins over a same-cycle abort: the byte is on the wire
                if (txBusy) begin
                    pop         = 1'b1;
                    txStartNext = 1'b0;
                    stateNext   = ST_WAIT;
                end else if (!en || flush) begin
                    txStartNext = 1'b0;
                    stateNext   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                txStartNext = 1'b0;
                if (!txBusy) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                txStartNext = 1'b0;
                stateNext   = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic       wrEn = 1'b0;
    logic [7:0] wrData = 8'h00;
    logic       full, empty, overflow, txEn, txStart;
    logic [4:0] count;
    logic [7:0] txByte;
    logic       txBusy = 1'b0;
    logic       txDone = 1'b0;

    logic       en4 = 1'b0;
    logic       flush4 = 1'b0;
    logic       wrEn4 = 1'b0;
    logic [7:0] wrData4 = 8'h00;
    logic       full4, empty4, overflow4, txEn4, txStart4;
    logic [2:0] count4;
    logic [7:0] txByte4;
    logic       busy4 = 1'b0;
    logic       txDone4 = 1'b0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstN(rstN), .en(en), .flush(flush), .wrEn(wrEn), .wrData(wrData),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .txEn(txEn),
        .txStart(txStart), .txByte(txByte), .txBusy(txBusy), .txDone(txDone)
    );

    uart_tx_feeder #(.DEPTH(4)) dut4 (
        .clk(clk), .rstN(rstN), .en(en4), .flush(flush4), .wrEn(wrEn4), .wrData(wrData4),
        .full(full4), .empty(empty4), .count(count4), .overflow(overflow4), .txEn(txEn4),
        .txStart(txStart4), .txByte(txByte4), .txBusy(busy4), .txDone(txDone4)
    );

    int         nCmp = 0;
    int         nErr = 0;
    int         cyc = 0;

    // reference: bytes accepted into the FIFO and not yet taken by Uart8
    logic [7:0] refQ[$];
    int         preCnt = 0;
    bit         expOvf = 1'b0;

    // Uart8 behavioural model state
    bit         mBusy = 1'b0;
    bit         seenStart = 1'b0;
    bit         gapChk = 1'b0;
    int         mLat = 0;
    int         mLeft = 0;
    int         latLo = 0, latHi = 0, busyLo = 1, busyHi = 1;
    int         sentCnt = 0;
    int         lastFall = -1;
    logic [7:0] lastSent = 8'h00;

    logic [7:0] sent4[$];
    logic [7:0] exp4[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCmp++;
        assert (obs === expv) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic setModel(input int lLo, input int lHi, input int bLo, input int bHi);
        latLo = lLo; latHi = lHi; busyLo = bLo; busyHi = bHi;
        mLat = $urandom_range(latHi, latLo);
    endtask

    // one cycle: sample at the falling edge, check against the reference, run the Uart8 models
    task automatic step();
        logic [7:0] expB;
        @(negedge clk);
        cyc++;
        chk("count", 32'(count), 32'(refQ.size()));
        chk("empty", 32'(empty), 32'(refQ.size() == 0));
        chk("full", 32'(full), 32'(refQ.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(expOvf));
        chk("txEn", 32'(txEn), 32'(en));
        expOvf = 1'b0;
        preCnt = refQ.size();
        txDone = 1'b0;
        if (mBusy) begin
            chk("txStartLowInWait", 32'(txStart), 32'd0);
            if (mLeft == 0) begin
                txBusy = 1'b0; txDone = 1'b1; mBusy = 1'b0; lastFall = cyc;
            end else begin
                mLeft--;
            end
        end else if (txStart === 1'b1) begin
            if (!seenStart) begin
                seenStart = 1'b1;
                if (gapChk && lastFall >= 0) chk("startGap", 32'(cyc - lastFall), 32'd2);
            end
            if (mLat == 0) begin
                txBusy = 1'b1; mBusy = 1'b1; seenStart = 1'b0;
                mLeft = $urandom_range(busyHi, busyLo);
                mLat = $urandom_range(latHi, latLo);
                chk("byteExpected", 32'(refQ.size() != 0), 32'd1);
                if (refQ.size() != 0) begin
                    expB = refQ.pop_front();
                    chk("txByte", 32'(txByte), 32'(expB));
                end
                lastSent = txByte;
                sentCnt++;
            end else begin
                mLat--;
            end
        end else begin
            seenStart = 1'b0;
            mLat = $urandom_range(latHi, latLo);
        end
        if (busy4) begin
            busy4 = 1'b0;
        end else if (txStart4 === 1'b1) begin
            busy4 = 1'b1;
            sent4.push_back(txByte4);
        end
    endtask

    task automatic tick(input bit wr, input logic [7:0] d, input bit fl);
        step();
        wrEn = wr; wrData = d; flush = fl;
        if (fl) refQ.delete();
        else if (wr) begin
            if (preCnt < DEPTH) refQ.push_back(d);
            else expOvf = 1'b1;
        end
    endtask

    task automatic drain(input int maxSteps);
        bit done = 1'b0;
        for (int i = 0; i < maxSteps && !done; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (refQ.size() == 0 && !mBusy && txStart == 1'b0) done = 1'b1;
        end
        chk("drainDone", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit hit;
        setModel(0, 0, 2, 2);

        // reset values
        #1 rstN = 1'b0;
        #1;
        chk("rstTxStart", 32'(txStart), 32'd0);
        chk("rstTxByte", 32'(txByte), 32'h00);
        chk("rstCount", 32'(count), 32'd0);
        chk("rstEmpty", 32'(empty), 32'd1);
        chk("rstFull", 32'(full), 32'd0);
        chk("rstOverflow", 32'(overflow), 32'd0);
        step(); step();
        rstN = 1'b1;
        step();

        // single byte: txStart two cycles after the push
        en = 1'b1;
        base = sentCnt;
        tick(1'b1, 8'b10001010, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        chk("latency1", 32'(txStart), 32'd0);
        tick(1'b0, 8'h00, 1'b0);
        chk("latency2", 32'(txStart), 32'd1);
        drain(50);
        chk("singleSent", 32'(sentCnt - base), 32'd1);
        chk("singleByte", 32'(lastSent), 32'h8A);

        // burst of 3 with start-gap checks
        en = 1'b0;
        tick(1'b1, 8'h55, 1'b0);
        tick(1'b1, 8'hA3, 1'b0);
        tick(1'b1, 8'h0F, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        chk("burstCount", 32'(count), 32'd3);
        base = sentCnt;
        lastFall = -1;
        gapChk = 1'b1;
        en = 1'b1;
        drain(100);
        gapChk = 1'b0;
        chk("burstSent", 32'(sentCnt - base), 32'd3);
        chk("burstLast", 32'(lastSent), 32'h0F);

        // overflow: 17 pushes into a disabled feeder
        setModel(0, 0, 1, 1);
        en = 1'b0;
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0);
        tick(1'b1, 8'h10, 1'b0);
        chk("fullAt16", 32'(full), 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        chk("ovfPulse", 32'(overflow), 32'd1);
        chk("ovfCount", 32'(count), 32'd16);
        tick(1'b0, 8'h00, 1'b0);
        chk("ovfOneCycle", 32'(overflow), 32'd0);
        base = sentCnt;
        en = 1'b1;
        drain(400);
        chk("ovfSent", 32'(sentCnt - base), 32'd16);
        chk("ovfLast", 32'(lastSent), 32'h0F);

        // flush while in START: request withdrawn, nothing sent
        setModel(20, 20, 1, 1);
        en = 1'b0;
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        en = 1'b1;
        base = sentCnt;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (txStart == 1'b1) hit = 1'b1;
        end
        chk("flushReachStart", 32'(hit), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
        chk("flushDropStart", 32'(txStart), 32'd0);
        chk("flushCount", 32'(count), 32'd0);
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b0);
        chk("flushNoSend", 32'(sentCnt - base), 32'd0);
        chk("flushIdle", 32'(txStart), 32'd0);

        // disable during WAIT: current byte completes, next one held
        setModel(0, 0, 4, 4);
        en = 1'b0;
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b1, 8'hC3, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (mBusy) hit = 1'b1;
        end
        chk("enReachWait", 32'(hit), 32'd1);
        en = 1'b0;
        base = sentCnt;
        for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 1'b0);
        chk("enHeldSent", 32'(sentCnt - base), 32'd0);
        chk("enHeldCount", 32'(count), 32'd1);
        chk("enHeldStart", 32'(txStart), 32'd0);
        chk("enFirstDone", 32'(lastSent), 32'h3C);
        en = 1'b1;
        drain(50);
        chk("enResumed", 32'(lastSent), 32'hC3);

        // async reset while in WAIT
        setModel(0, 0, 6, 6);
        en = 1'b0;
        tick(1'b1, 8'h5A, 1'b0);
        tick(1'b1, 8'hA5, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (mBusy) hit = 1'b1;
        end
        chk("rstReachWait", 32'(hit), 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        chk("rstPreCount", 32'(count), 32'd1);
        #2 rstN = 1'b0;
        #1;
        chk("arstTxStart", 32'(txStart), 32'd0);
        chk("arstCount", 32'(count), 32'd0);
        chk("arstEmpty", 32'(empty), 32'd1);
        refQ.delete();
        expOvf = 1'b0;
        base = sentCnt;
        step(); step();
        rstN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            chk("arstNoStart", 32'(txStart), 32'd0);
        end
        chk("arstNoSend", 32'(sentCnt - base), 32'd0);

        // randomized traffic with enable toggles and occasional flush
        setModel(0, 3, 0, 5);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19, 0) == 0) en = !en;
            tick(1'(($urandom_range(1, 0))), 8'($urandom), ($urandom_range(39, 0) == 0));
        end
        en = 1'b1;
        drain(1500);

        // DEPTH=4 wrap-around: push 3, drain, push 4, drain
        en4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            wrEn4 = 1'b1; wrData4 = 8'($urandom);
            exp4.push_back(wrData4);
        end
        step();
        wrEn4 = 1'b0;
        en4 = 1'b1;
        for (int i = 0; i < 40 && sent4.size() < 3; i++) step();
        chk("wrap4FirstCount", 32'(sent4.size()), 32'd3);
        for (int i = 0; i < 4; i++) step();
        en4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            wrEn4 = 1'b1; wrData4 = 8'($urandom);
            exp4.push_back(wrData4);
        end
        step();
        wrEn4 = 1'b0;
        step();
        chk("wrap4Full", 32'(full4), 32'd1);
        chk("wrap4Count", 32'(count4), 32'd4);
        en4 = 1'b1;
        for (int i = 0; i < 60 && sent4.size() < 7; i++) step();
        chk("wrap4Total", 32'(sent4.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < sent4.size()) chk("wrap4Byte", 32'(sent4[i]), 32'(exp4[i]));
        end
        step();
        chk("wrap4Empty", 32'(empty4), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
